// File: rtl/alu_pkg.sv
// Shared ALU definitions: alu_control opcodes, RV32I opcode/funct constants, decode record.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package alu_pkg;

    // ALU operation codes, shared with the execute ALU
    localparam logic [5:0] ALU_NOP = 6'd0;
    localparam logic [5:0] ALU_ADD = 6'd1;
    localparam logic [5:0] ALU_SUB = 6'd2;
    localparam logic [5:0] ALU_SLL = 6'd3;
    localparam logic [5:0] ALU_SLT = 6'd4;
    localparam logic [5:0] ALU_OR  = 6'd5;
    localparam logic [5:0] ALU_XOR = 6'd6;
    localparam logic [5:0] ALU_SGT = 6'd7;  // reserved, never issued by this stage

    // RV32I major opcodes
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    // funct3 values
    localparam logic [2:0] F3_ADD = 3'd0;
    localparam logic [2:0] F3_SLL = 3'd1;
    localparam logic [2:0] F3_SLT = 3'd2;
    localparam logic [2:0] F3_XOR = 3'd4;
    localparam logic [2:0] F3_OR  = 3'd6;

    // funct7 values
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_SUB  = 7'h20;

    // Decoded instruction record
    typedef struct packed {
        logic [5:0] alu_control;
        logic       is_imm;     // src2 comes from the immediate
        logic       uses_rs2;   // rs2 participates in hazard checks
        logic       shift_imm;  // SLLI: shamt taken from instr[23:20]
        logic       legal;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
    } dec_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32I integer-subset decoder: instr -> alu_control, operand kind, legality, imm.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; stateless.
// Ports: i_instr (instruction word), o_dec (decoded record), o_imm (imm[11:0] truncated to DATA_W).
module alu_issue_decode
    import alu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [31:0]       i_instr,
    output dec_t              o_dec,
    output logic [DATA_W-1:0] o_imm
);

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [6:0] w_f7;

    assign w_opcode = i_instr[6:0];
    assign w_f3     = i_instr[14:12];
    assign w_f7     = i_instr[31:25];

    // Sign-extend-then-fit keeps the low bits of imm[11:0] for narrow operands
    assign o_imm = DATA_W'($signed(i_instr[31:20]));

    always_comb begin
        o_dec           = '0;
        o_dec.rd        = i_instr[11:7];
        o_dec.rs1       = i_instr[19:15];
        o_dec.rs2       = i_instr[24:20];
        o_dec.alu_control = ALU_NOP;
        case (w_opcode)
            OP_R: begin
                o_dec.uses_rs2 = 1'b1;
                if (w_f7 == F7_BASE) begin
                    o_dec.legal = 1'b1;
                    case (w_f3)
                        F3_ADD:  o_dec.alu_control = ALU_ADD;
                        F3_SLL:  o_dec.alu_control = ALU_SLL;
                        F3_SLT:  o_dec.alu_control = ALU_SLT;
                        F3_XOR:  o_dec.alu_control = ALU_XOR;
                        F3_OR:   o_dec.alu_control = ALU_OR;
                        default: o_dec.legal = 1'b0;
                    endcase
                end else if (w_f7 == F7_SUB && w_f3 == F3_ADD) begin
                    o_dec.legal       = 1'b1;
                    o_dec.alu_control = ALU_SUB;
                end
            end
            OP_I: begin
                o_dec.is_imm = 1'b1;
                o_dec.legal  = 1'b1;
                case (w_f3)
                    F3_ADD: o_dec.alu_control = ALU_ADD;
                    F3_SLT: o_dec.alu_control = ALU_SLT;
                    F3_XOR: o_dec.alu_control = ALU_XOR;
                    F3_OR:  o_dec.alu_control = ALU_OR;
                    F3_SLL: begin
                        if (w_f7 == F7_BASE) begin
                            o_dec.alu_control = ALU_SLL;
                            o_dec.shift_imm   = 1'b1;
                        end else begin
                            o_dec.legal = 1'b0;
                        end
                    end
                    default: o_dec.legal = 1'b0;
                endcase
            end
            default: o_dec.legal = 1'b0;
        endcase
        // Illegal instructions must not create hazards or carry an opcode
        if (!o_dec.legal) begin
            o_dec.alu_control = ALU_NOP;
            o_dec.uses_rs2    = 1'b0;
            o_dec.shift_imm   = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// Decode/issue stage: regfile read, busy scoreboard, registered operand slot for the ALU.
// Latency: 1 cycle from in_valid&&in_ready to out_valid; illegal pulses 1 cycle after acceptance.
// Backpressure: in_ready low on RAW/WAW hazard or when the held slot is not consumed (out_ready low).
// Ports: in_* instruction handshake; out_* ALU operands/opcode/rd; illegal pulse; wb_* writeback.
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int SHAMT_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_src1,
    output logic [DATA_W-1:0]  out_src2,
    output logic [5:0]         out_alu_control,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic [4:0]         out_rd,
    output logic               illegal,
    input  logic               wb_en,
    input  logic [4:0]         wb_rd,
    input  logic [DATA_W-1:0]  wb_data
);

    dec_t               w_dec;
    logic [DATA_W-1:0]  w_imm;

    alu_issue_decode #(.DATA_W(DATA_W)) u_decode (
        .i_instr (in_instr),
        .o_dec   (w_dec),
        .o_imm   (w_imm)
    );

    logic [DATA_W-1:0]  r_regs [32];
    logic [31:0]        r_busy;
    logic [31:0]        w_busy_nxt;
    logic               r_rst_done;   // holds in_ready low until the first edge after reset
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_src1;
    logic [DATA_W-1:0]  r_out_src2;
    logic [5:0]         r_out_ctrl;
    logic [SHAMT_W-1:0] r_out_shamt;
    logic [4:0]         r_out_rd;
    logic               r_illegal;

    logic               w_wb_rs1;
    logic               w_wb_rs2;
    logic               w_wb_rd;
    logic               w_stall;
    logic               w_slot_free;
    logic               w_accept;
    logic               w_issue;
    logic [DATA_W-1:0]  w_rs1_val;
    logic [DATA_W-1:0]  w_rs2_val;
    logic [DATA_W-1:0]  w_src2;
    logic [SHAMT_W-1:0] w_shamt;

    // Writeback hits this cycle (x0 is never written, so never a hit)
    assign w_wb_rs1 = wb_en && (wb_rd == w_dec.rs1) && (w_dec.rs1 != 5'd0);
    assign w_wb_rs2 = wb_en && (wb_rd == w_dec.rs2) && (w_dec.rs2 != 5'd0);
    assign w_wb_rd  = wb_en && (wb_rd == w_dec.rd)  && (w_dec.rd  != 5'd0);

    // Same-cycle writeback bypasses the regfile
    assign w_rs1_val = w_wb_rs1 ? wb_data : r_regs[w_dec.rs1];
    assign w_rs2_val = w_wb_rs2 ? wb_data : r_regs[w_dec.rs2];

    // A busy bit being cleared this cycle does not stall; illegal ops never stall
    assign w_stall = w_dec.legal &&
                     ((r_busy[w_dec.rs1] && !w_wb_rs1) ||
                      (w_dec.uses_rs2 && r_busy[w_dec.rs2] && !w_wb_rs2) ||
                      (r_busy[w_dec.rd] && !w_wb_rd));

    assign w_slot_free = !r_out_valid || out_ready;
    assign in_ready    = r_rst_done && w_slot_free && !w_stall;
    assign w_accept    = in_valid && in_ready;
    assign w_issue     = w_accept && w_dec.legal;

    always_comb begin
        w_src2  = w_rs2_val;
        w_shamt = w_rs2_val[SHAMT_W-1:0];
        if (w_dec.is_imm) begin
            w_src2  = w_imm;
            w_shamt = '0;
            if (w_dec.shift_imm) begin
                w_shamt = w_dec.rs2[SHAMT_W-1:0];
                w_src2  = DATA_W'(w_dec.rs2[SHAMT_W-1:0]);
            end
        end
    end

    // Clear on writeback first, then set on issue so set wins for the same register
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_en) begin
            w_busy_nxt[wb_rd] = 1'b0;
        end
        if (w_issue && w_dec.rd != 5'd0) begin
            w_busy_nxt[w_dec.rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_rst_done <= 1'b0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_rst_done <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else if (wb_en && wb_rd != 5'd0) begin
            r_regs[wb_rd] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_src1  <= '0;
            r_out_src2  <= '0;
            r_out_ctrl  <= ALU_NOP;
            r_out_shamt <= '0;
            r_out_rd    <= '0;
            r_illegal   <= 1'b0;
        end else begin
            r_illegal <= w_accept && !w_dec.legal;
            if (w_issue) begin
                r_out_valid <= 1'b1;
                r_out_src1  <= w_rs1_val;
                r_out_src2  <= w_src2;
                r_out_ctrl  <= w_dec.alu_control;
                r_out_shamt <= w_shamt;
                r_out_rd    <= w_dec.rd;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid       = r_out_valid;
    assign out_src1        = r_out_src1;
    assign out_src2        = r_out_src2;
    assign out_alu_control = r_out_ctrl;
    assign out_shamt       = r_out_shamt;
    assign out_rd          = r_out_rd;
    assign illegal         = r_illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: reset, RAW stall, SLLI, bypass, output hold, illegal, mid-run reset.
// Latency: checks the 1-cycle issue latency and 1-cycle illegal pulse.
// Backpressure: exercises in_ready under hazards and out_ready low.
module tb_alu_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_src1;
    logic [7:0]  out_src2;
    logic [5:0]  out_alu_control;
    logic [3:0]  out_shamt;
    logic [4:0]  out_rd;
    logic        illegal;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [7:0]  wb_data;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_slot;
    logic [31:0] obs_slot;

    // {valid, src1, src2, ctrl, shamt, rd}
    assign obs_slot = {out_valid, out_src1, out_src2, out_alu_control, out_shamt, out_rd};

    always #5 clk = ~clk;

    alu_issue #(.DATA_W(8), .SHAMT_W(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instr        (in_instr),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_src1        (out_src1),
        .out_src2        (out_src2),
        .out_alu_control (out_alu_control),
        .out_shamt       (out_shamt),
        .out_rd          (out_rd),
        .illegal         (illegal),
        .wb_en           (wb_en),
        .wb_rd           (wb_rd),
        .wb_data         (wb_data)
    );

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic en, input logic [4:0] rd, input logic [7:0] data);
        wb_en   = en;
        wb_rd   = rd;
        wb_data = data;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
        wb(1'b0, 5'd0, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs_slot !== 32'h0) begin errors++; $display("FAIL reset_slot: got %h expected %h", obs_slot, 32'h0); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++;
        if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_instr = enc_i(12'd5, 5'd0, 3'd0, 5'd1);   // addi x1,x0,5
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_ready_addi1: got %b expected 1", in_ready); end
        tick();
        exp_slot = {1'b1, 8'd0, 8'd5, 6'd1, 4'd0, 5'd1};
        checks++;
        if (obs_slot !== exp_slot) begin errors++; $display("FAIL raw_slot_addi1: got %h expected %h", obs_slot, exp_slot); end
        in_instr = enc_i(12'd3, 5'd0, 3'd0, 5'd2);                      // addi x2,x0,3
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_ready_addi2: got %b expected 1", in_ready); end
        tick();
        exp_slot = {1'b1, 8'd0, 8'd3, 6'd1, 4'd0, 5'd2};
        checks++;
        if (obs_slot !== exp_slot) begin errors++; $display("FAIL raw_slot_addi2: got %h expected %h", obs_slot, exp_slot); end
        in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd3);                // add x3,x1,x2
        wb(1'b1, 5'd1, 8'd5);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL raw_stall_x2: got %b expected 0", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL raw_bubble: got %b expected 0", out_valid); end
        wb(1'b1, 5'd2, 8'd3);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL raw_release: got %b expected 1", in_ready); end
        tick();
        exp_slot = {1'b1, 8'd5, 8'd3, 6'd1, 4'd3, 5'd3};
        checks++;
        if (obs_slot !== exp_slot) begin errors++; $display("FAIL raw_slot_add: got %h expected %h", obs_slot, exp_slot); end
        in_valid = 1'b0;
        wb(1'b1, 5'd3, 8'd8);
        tick();
        wb(1'b0, 5'd0, 8'd0);
    endtask

    task automatic test_slli();
        in_valid = 1'b1; in_instr = enc_i(12'd3, 5'd1, 3'd1, 5'd4);    // slli x4,x1,3
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL slli_ready: got %b expected 1", in_ready); end
        tick();
        exp_slot = {1'b1, 8'd5, 8'd3, 6'd3, 4'd3, 5'd4};
        checks++;
        if (obs_slot !== exp_slot) begin errors++; $display("FAIL slli_slot: got %h expected %h", obs_slot, exp_slot); end
        in_valid = 1'b0;
        wb(1'b1, 5'd4, 8'd40);
        tick();
        wb(1'b0, 5'd0, 8'd0);
    endtask

    task automatic test_bypass();
        in_valid = 1'b1; in_instr = enc_i(12'd9, 5'd0, 3'd0, 5'd2);    // addi x2,x0,9
        tick();
        exp_slot = {1'b1, 8'd0, 8'd9, 6'd1, 4'd0, 5'd2};
        checks++;
        if (obs_slot !== exp_slot) begin errors++; $display("FAIL byp_slot_addi: got %h expected %h", obs_slot, exp_slot); end
        in_instr = enc_r(7'h20, 5'd2, 5'd1, 3'd0, 5'd5);                // sub x5,x1,x2
        wb(1'b1, 5'd2, 8'd9);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL byp_no_stall: got %b expected 1", in_ready); end
        tick();
        exp_slot = {1'b1, 8'd5, 8'd9, 6'd2, 4'd9, 5'd5};
        checks++;
        if (obs_slot !== exp_slot) begin errors++; $display("FAIL byp_slot_sub: got %h expected %h", obs_slot, exp_slot); end
        in_valid = 1'b0;
        wb(1'b1, 5'd5, 8'hFC);
        tick();
        wb(1'b0, 5'd0, 8'd0);
    endtask

    task automatic test_hold();
        in_valid = 1'b1; out_ready = 1'b1;
        in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd6);                // or x6,x1,x2
        tick();
        exp_slot = {1'b1, 8'd5, 8'd9, 6'd5, 4'd9, 5'd6};
        checks++;
        if (obs_slot !== exp_slot) begin errors++; $display("FAIL hold_slot_or: got %h expected %h", obs_slot, exp_slot); end
        out_ready = 1'b0;
        in_instr = enc_i(12'h00F, 5'd0, 3'd4, 5'd9);                   // xori x9,x0,15
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_ready[%0d]: got %b expected 0", i, in_ready); end
            checks++;
            if (obs_slot !== exp_slot) begin errors++; $display("FAIL hold_stable[%0d]: got %h expected %h", i, obs_slot, exp_slot); end
            tick();
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready: got %b expected 1", in_ready); end
        tick();
        exp_slot = {1'b1, 8'd0, 8'd15, 6'd6, 4'd0, 5'd9};
        checks++;
        if (obs_slot !== exp_slot) begin errors++; $display("FAIL hold_next_xori: got %h expected %h", obs_slot, exp_slot); end
        in_valid = 1'b0;
        wb(1'b1, 5'd6, 8'd13);
        tick();
        wb(1'b1, 5'd9, 8'd15);
        tick();
        wb(1'b0, 5'd0, 8'd0);
    endtask

    task automatic test_illegal();
        in_valid = 1'b1; in_instr = 32'h0000_0073;                     // ecall
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ill_ecall_ready: got %b expected 1", in_ready); end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({illegal, out_valid} !== 2'b10) begin errors++; $display("FAIL ill_ecall_pulse: got %b expected 10", {illegal, out_valid}); end
        tick();
        checks++;
        if ({illegal, out_valid} !== 2'b00) begin errors++; $display("FAIL ill_ecall_end: got %b expected 00", {illegal, out_valid}); end
        in_valid = 1'b1; in_instr = enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd11);  // sltu: unsupported
        tick();
        checks++;
        if ({illegal, out_valid} !== 2'b10) begin errors++; $display("FAIL ill_sltu_pulse: got %b expected 10", {illegal, out_valid}); end
        in_instr = enc_i(12'd1, 5'd11, 3'd0, 5'd11);                   // addi x11,x11,1
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ill_no_busy: got %b expected 1", in_ready); end
        tick();
        exp_slot = {1'b1, 8'd0, 8'd1, 6'd1, 4'd0, 5'd11};
        checks++;
        if ({illegal, obs_slot} !== {1'b0, exp_slot}) begin errors++; $display("FAIL ill_after_addi: got %b_%h expected 0_%h", illegal, obs_slot, exp_slot); end
        in_valid = 1'b0;
        wb(1'b1, 5'd11, 8'd1);
        tick();
        wb(1'b0, 5'd0, 8'd0);
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = enc_i(12'd7, 5'd0, 3'd0, 5'd7);    // addi x7,x0,7
        tick();
        in_valid = 1'b0;
        exp_slot = {1'b1, 8'd0, 8'd7, 6'd1, 4'd0, 5'd7};
        checks++;
        if (obs_slot !== exp_slot) begin errors++; $display("FAIL rstm_slot_before: got %h expected %h", obs_slot, exp_slot); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs_slot !== 32'h0) begin errors++; $display("FAIL rstm_async_clear: got %h expected %h", obs_slot, 32'h0); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rstm_in_ready: got %b expected 0", in_ready); end
        tick();
        rst_n = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b1; in_instr = enc_i(12'd1, 5'd7, 3'd0, 5'd8);    // addi x8,x7,1
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rstm_no_stall: got %b expected 1", in_ready); end
        tick();
        exp_slot = {1'b1, 8'd0, 8'd1, 6'd1, 4'd0, 5'd8};
        checks++;
        if (obs_slot !== exp_slot) begin errors++; $display("FAIL rstm_slot_addi8: got %h expected %h", obs_slot, exp_slot); end
        in_valid = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_slli();
        test_bypass();
        test_hold();
        test_illegal();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
